inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//   Fetch stage upstream of the main opcode decoder. Holds the PC and issues word reads to
//   instruction memory over a valid/ready request and valid response interface.
//   Presents one registered instruction, its PC and its opcode field to the decoder with
//   valid/ready flow control. Takes branch/jump redirects from the execute path.
// PARAMETERS
//   ADDR_W    32             PC / instruction-memory address width
//   RESET_PC  32'h0000_0000  first fetch address after reset
//   NOP_INSTR 32'h0000_0013  value driven on if_instr while empty (addi x0,x0,0)
// PORTS
//   clk             in   1       rising-edge clock
//   rst_n           in   1       asynchronous active-low reset
//   imem_req_valid  out  1       fetch request valid
//   imem_req_ready  in   1       memory accepts request this cycle
//   imem_addr       out  ADDR_W  fetch address (word aligned)
//   imem_rsp_valid  in   1       read data valid (one response per accepted request, >=1 cycle later)
//   imem_rsp_data   in   32      instruction word
//   if_valid        out  1       if_instr/if_pc hold a live instruction
//   if_ready        in   1       decoder consumes instruction this cycle
//   if_instr        out  32      instruction word
//   if_pc           out  ADDR_W  address of if_instr
//   if_opcode       out  7       if_instr[6:0], feeds decoder OpCode
//   redirect_valid  in   1       taken branch / jal: refetch from redirect_pc
//   redirect_pc     in   ADDR_W  target; bits[1:0] ignored
//   misalign_err    out  1       one-cycle pulse: redirect_pc[1:0] != 0
// BEHAVIOUR
//   Reset (async assert, sync release): pc=RESET_PC, state=REQ, imem_req_valid=0, if_valid=0,
//     if_instr=NOP_INSTR, if_pc=0, misalign_err=0. No request while rst_n low.
//   States: REQ, WAIT, DROP. At most one request outstanding; one-entry output register.
//   REQ : imem_req_valid = !if_valid | if_ready (stalls when output full and not consumed);
//         imem_addr=pc. On req_valid & req_ready -> WAIT.
//   WAIT: on imem_rsp_valid: if_instr<=rsp_data, if_pc<=pc, if_valid<=1, pc<=pc+4, -> REQ.
//   DROP: response of a squashed fetch; on imem_rsp_valid discard data, -> REQ.
//   Output: if_valid & if_ready clears if_valid (unless refilled same cycle);
//     if_valid & !if_ready holds if_instr/if_pc stable. if_instr=NOP_INSTR whenever !if_valid.
//   Best throughput: one instruction per 2 cycles for a 1-cycle memory (REQ, WAIT alternate).
//   Latency: request accepted in cycle N, response in N+1 -> if_valid from N+2.
//   Redirect (highest priority, every state): pc<={redirect_pc[ADDR_W-1:2],2'b00}; if_valid<=0
//     (buffered instruction flushed, even if if_ready same cycle);
//     REQ with handshake completing same cycle -> DROP; REQ otherwise -> REQ;
//     WAIT with no rsp_valid -> DROP; WAIT with rsp_valid same cycle -> data discarded, -> REQ;
//     DROP -> stays DROP (pc updated, pending response still discarded).
//     misalign_err=1 in the cycle after a redirect with redirect_pc[1:0]!=0.
//   PC arithmetic: modulo 2^ADDR_W; pc 'hFFFF_FFFC + 4 wraps to 0 silently.
//   Reset mid-fetch: state and pc reset immediately; a late response after release is ignored
//     (state REQ ignores imem_rsp_valid).
// TESTING
//   T1 reset/sequential: RESET_PC=0, 1-cycle mem, if_ready=1 -> if_pc 0,4,8,C on cycles 2,4,6,8;
//      if_opcode = rsp_data[6:0].
//   T2 backpressure: if_ready=0 for 5 cycles at if_pc=8 -> if_instr/if_pc stable, no new req;
//      if_ready=1 -> next req addr=C.
//   T3 redirect in WAIT: redirect_pc=0x100 while fetch of 0x10 outstanding -> 0x10 data dropped,
//      next imem_addr=0x100, first if_pc=0x100.
//   T4 redirect + rsp same cycle, and redirect_pc=0x203 -> data dropped, imem_addr=0x200,
//      misalign_err pulses one cycle.
//   T5 wrap: redirect to 'hFFFF_FFFC -> if_pc 'hFFFF_FFFC then 'h0000_0000.
//   T6 async reset asserted in WAIT with 3-cycle mem -> outputs at reset values immediately;
//      stale rsp ignored; first fetch RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads to instruction
// memory and presents one buffered instruction to the decoder with valid/ready flow control.
module inst_fetch_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [6:0]        if_opcode,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              misalign_err
);

    typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr_q;
    logic              req_fire;

    // A new request is only issued when the output slot is free or being drained this cycle.
    assign imem_req_valid = rst_n && (state == REQ) && (!if_valid || if_ready);
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_instr  = if_valid ? instr_q : NOP_INSTR;
    assign if_opcode = if_instr[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= REQ;
            pc           <= RESET_PC;
            instr_q      <= NOP_INSTR;
            if_pc        <= '0;
            if_valid     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
                if_valid <= 1'b0;
                unique case (state)
                    REQ:     if (req_fire) state <= DROP;
                    WAIT:    state <= imem_rsp_valid ? REQ : DROP;
                    // A response landing now is the squashed one; nothing is left to discard.
                    DROP:    if (imem_rsp_valid) state <= REQ;
                    default: state <= REQ;
                endcase
            end else begin
                if (if_valid && if_ready) if_valid <= 1'b0;
                unique case (state)
                    REQ: if (req_fire) state <= WAIT;
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            instr_q  <= imem_rsp_data;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= pc + ADDR_W'(4);
                            state    <= REQ;
                        end
                    end
                    DROP:    if (imem_rsp_valid) state <= REQ;
                    default: state <= REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a variable-latency instruction memory model.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        misalign_err;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned lat = 1;
    int unsigned m_cnt = 0;
    logic [31:0] m_addr = '0;

    inst_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_opcode(if_opcode), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A00_0013;
    endfunction

    // Memory answers exactly lat cycles after accepting a request; it ignores DUT reset.
    always @(posedge clk) begin
        if (imem_req_valid && imem_req_ready) begin
            m_addr <= imem_addr;
            m_cnt  <= lat;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign imem_rsp_valid = (m_cnt == 1);
    assign imem_rsp_data  = memf(m_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, 32'(if_valid), 32'd1);
        check({tag, ".pc"}, if_pc, pc);
        check({tag, ".instr"}, if_instr, memf(pc));
        check({tag, ".opcode"}, 32'(if_opcode), 32'(memf(pc) & 32'h7F));
    endtask

    logic [31:0] held;

    initial begin
        // Reset values
        step();
        check("rst.req_valid", 32'(imem_req_valid), 32'd0);
        check("rst.if_valid", 32'(if_valid), 32'd0);
        check("rst.if_instr", if_instr, NOP);
        check("rst.if_pc", if_pc, 32'h0);
        check("rst.misalign", 32'(misalign_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t1.req_valid0", 32'(imem_req_valid), 32'd1);
        check("t1.addr0", imem_addr, 32'h0);

        // T1: sequential fetch, 1-cycle memory, one instruction every 2 cycles
        for (int k = 0; k < 3; k++) begin
            step();
            check("t1.gap_valid", 32'(if_valid), 32'd0);
            check("t1.gap_instr", if_instr, NOP);
            step();
            check_out("t1", 32'(k * 4));
        end

        // T2: backpressure holds the buffered instruction at pc 8
        if_ready = 1'b0;
        #1;
        check("t2.req_stall", 32'(imem_req_valid), 32'd0);
        held = if_instr;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t2.hold_pc", if_pc, 32'h8);
            check("t2.hold_instr", if_instr, held);
            check("t2.hold_req", 32'(imem_req_valid), 32'd0);
        end
        if_ready = 1'b1;
        #1;
        check("t2.req_resume", 32'(imem_req_valid), 32'd1);
        check("t2.addr", imem_addr, 32'hC);
        step();
        step();
        check_out("t2", 32'hC);

        // T3: redirect while the 0x10 fetch is still outstanding (2-cycle memory)
        lat = 2;
        step();
        check("t3.wait_rsp", 32'(imem_rsp_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        lat = 1;
        check("t3.drop_valid", 32'(if_valid), 32'd0);
        check("t3.drop_req", 32'(imem_req_valid), 32'd0);
        step();
        check("t3.dropped", 32'(if_valid), 32'd0);
        check("t3.req_valid", 32'(imem_req_valid), 32'd1);
        check("t3.addr", imem_addr, 32'h100);
        step();
        step();
        check_out("t3", 32'h100);

        // T4: redirect with response in the same cycle, misaligned target
        step();
        check("t4.rsp_now", 32'(imem_rsp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect_valid = 1'b0;
        check("t4.dropped", 32'(if_valid), 32'd0);
        check("t4.misalign_hi", 32'(misalign_err), 32'd1);
        check("t4.addr", imem_addr, 32'h200);
        step();
        check("t4.misalign_lo", 32'(misalign_err), 32'd0);
        step();
        check_out("t4", 32'h200);

        // T5: redirect during a completing request, then PC wraps past the top
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("t5.flush", 32'(if_valid), 32'd0);
        check("t5.drop_req", 32'(imem_req_valid), 32'd0);
        check("t5.misalign", 32'(misalign_err), 32'd0);
        step();
        check("t5.addr", imem_addr, 32'hFFFF_FFFC);
        step();
        step();
        check_out("t5.top", 32'hFFFF_FFFC);
        step();
        step();
        check_out("t5.wrap", 32'h0);

        // T6: async reset in WAIT with a 3-cycle memory; stale response must be ignored
        lat = 3;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("t6.req_valid", 32'(imem_req_valid), 32'd0);
        check("t6.if_valid", 32'(if_valid), 32'd0);
        check("t6.if_instr", if_instr, NOP);
        check("t6.if_pc", if_pc, 32'h0);
        check("t6.addr", imem_addr, 32'h0);
        imem_req_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("t6.stale_rsp", 32'(imem_rsp_valid), 32'd1);
        check("t6.addr_rst", imem_addr, 32'h0);
        step();
        check("t6.stale_ign", 32'(if_valid), 32'd0);
        lat = 1;
        imem_req_ready = 1'b1;
        step();
        step();
        check_out("t6", 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
